// File: rtl/cond_logic.sv
// cond_logic: ARM conditional-execution stage holding NZCV flags and gating PC/register/memory writes
module cond_logic (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);
    logic n, z, c, v, ge;
    logic [1:0] flag_write;
    assign {n, z, c, v} = Flags;
    assign ge = n == v;
    always_comb begin
        case (Cond)
            4'b0000: CondEx = z;
            4'b0001: CondEx = ~z;
            4'b0010: CondEx = c;
            4'b0011: CondEx = ~c;
            4'b0100: CondEx = n;
            4'b0101: CondEx = ~n;
            4'b0110: CondEx = v;
            4'b0111: CondEx = ~v;
            4'b1000: CondEx = c & ~z;
            4'b1001: CondEx = ~c | z;
            4'b1010: CondEx = ge;
            4'b1011: CondEx = ~ge;
            4'b1100: CondEx = ~z & ge;
            4'b1101: CondEx = z | ~ge;
            4'b1110: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end
    assign flag_write = FlagW & {2{CondEx}};
    // Gated writes are held off while reset is asserted, even though CondEx keeps evaluating.
    assign PCSrc    = PCS & CondEx & reset_n;
    assign RegWrite = RegW & CondEx & ~NoWrite & reset_n;
    assign MemWrite = MemW & CondEx & reset_n;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            Flags <= 4'b0000;
        end else begin
            if (flag_write[1]) Flags[3:2] <= ALUFlags[3:2];
            if (flag_write[0]) Flags[1:0] <= ALUFlags[1:0];
        end
    end
endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: directed scoreboard bench; expected {PCSrc,RegWrite,MemWrite,CondEx,Flags} queued, monitor compares
module tb_cond_logic;
    logic       clk = 0, reset_n = 0;
    logic [3:0] Cond = 0, ALUFlags = 0;
    logic [1:0] FlagW = 0;
    logic       PCS = 0, RegW = 0, MemW = 0, NoWrite = 0;
    logic       PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } item_t;

    item_t q[$];
    event  chk;
    int    tests = 0, fails = 0;

    cond_logic dut (
        .clk(clk), .reset_n(reset_n), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags)
    );

    always #5 clk = ~clk;

    function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
        logic fn, fz, fc, fv;
        {fn, fz, fc, fv} = f;
        case (c)
            4'h0: return fz;
            4'h1: return !fz;
            4'h2: return fc;
            4'h3: return !fc;
            4'h4: return fn;
            4'h5: return !fn;
            4'h6: return fv;
            4'h7: return !fv;
            4'h8: return fc && !fz;
            4'h9: return !fc || fz;
            4'hA: return fn == fv;
            4'hB: return fn != fv;
            4'hC: return !fz && (fn == fv);
            4'hD: return fz || (fn != fv);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic [3:0] c, input logic [3:0] a, input logic [1:0] fw,
                         input logic p, input logic r, input logic m, input logic nw);
        Cond = c; ALUFlags = a; FlagW = fw; PCS = p; RegW = r; MemW = m; NoWrite = nw;
    endtask

    task automatic check(input string nm, input logic [7:0] e);
        item_t it;
        it.name = nm;
        it.exp  = e;
        q.push_back(it);
        #1 -> chk;
        @(negedge clk);
    endtask

    task automatic set_flags(input logic [3:0] f);
        drive(4'hE, f, 2'b11, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    initial begin : monitor
        item_t      it;
        logic [7:0] act;
        forever begin
            @(chk);
            act = {PCSrc, RegWrite, MemWrite, CondEx, Flags};
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL no_expected: got %b with empty queue", act);
            end else begin
                it = q.pop_front();
                if (act !== it.exp) begin
                    fails++;
                    $display("FAIL %s: got %b expected %b", it.name, act, it.exp);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        drive(4'hE, 0, 0, 0, 1, 0, 0);
        check("rst_al", 8'b0001_0000);
        drive(4'h0, 0, 0, 0, 1, 0, 0);
        check("rst_eq", 8'b0000_0000);
        drive(4'h5, 0, 0, 1, 1, 1, 0);
        check("rst_pl", 8'b0001_0000);
        drive(4'hE, 0, 0, 0, 1, 0, 0);
        #1 reset_n = 1;
        check("release_regw", 8'b0101_0000);

        drive(4'hE, 4'b0100, 2'b11, 0, 0, 0, 0);
        check("set_z_old", 8'b0001_0000);
        drive(4'h0, 0, 0, 0, 0, 0, 0);
        check("eq_after_z", 8'b0001_0100);
        drive(4'h1, 0, 0, 0, 0, 0, 0);
        check("ne_after_z", 8'b0000_0100);

        set_flags(4'hF);
        drive(4'hE, 4'h0, 2'b10, 0, 0, 0, 0);
        check("split_hi_old", 8'b0001_1111);
        drive(4'hE, 4'h0, 2'b01, 0, 0, 0, 0);
        check("split_hi", 8'b0001_0011);
        drive(4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        check("split_lo", 8'b0001_0000);

        drive(4'h0, 4'b1010, 2'b11, 1, 1, 1, 0);
        check("fail_gates", 8'b0000_0000);
        drive(4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        check("fail_noflags", 8'b0001_0000);

        set_flags(4'b1001);
        drive(4'hA, 0, 0, 0, 0, 0, 0);
        check("spot_ge", 8'b0001_1001);
        drive(4'hB, 0, 0, 0, 0, 0, 0);
        check("spot_lt", 8'b0000_1001);
        drive(4'hC, 0, 0, 0, 0, 0, 0);
        check("spot_gt", 8'b0001_1001);
        set_flags(4'b1100);
        drive(4'hD, 0, 0, 0, 0, 0, 0);
        check("spot_le", 8'b0001_1100);

        for (int f = 0; f < 16; f++) begin
            set_flags(f[3:0]);
            for (int c = 0; c < 16; c++) begin
                logic ce;
                ce = cond_ref(c[3:0], f[3:0]);
                drive(c[3:0], 4'h0, 2'b00, 1, 1, 1, 0);
                check($sformatf("sweep_f%0h_c%0h", f, c), {ce, ce, ce, ce, f[3:0]});
            end
        end

        drive(4'hE, 4'b0110, 2'b11, 0, 1, 0, 1);
        check("cmp_noregw", 8'b0001_1111);
        drive(4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        check("cmp_flags", 8'b0001_0110);

        drive(4'hE, 4'hF, 2'b11, 1, 1, 1, 0);
        #1 reset_n = 0;
        check("async_rst_now", 8'b0001_0000);
        check("async_rst_edge", 8'b0001_0000);
        reset_n = 1;
        drive(4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
        check("post_rst", 8'b0001_0000);

        #2;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL leftover: %0d expected entries never compared, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
